pattern_lut_scrub: RTL
======================

PATTERN_LUT_SCRUB -- requirements
Module: pattern_lut_scrub

Interface
REQ-001 Parameter MXADRB, default 12, is the pattern ROM address width.
REQ-002 Parameter MXDATB, default 18, is the ROM data width: {quality, bend, qs}.
REQ-003 Parameter MXPIDB, default 4, is the pattern ID width.
REQ-004 Parameter PID_MIN, default 2, is the lowest valid pattern ID.
REQ-005 Parameter PID_MAX, default 10 (0xA), is the highest valid pattern ID.
REQ-006 Port clock, in, 1: the single clock; everything is on its rising edge.
REQ-007 Port reset, in, 1: synchronous, active-high.
REQ-008 Port trig_req, in, 1: the trigger path needs the ROM port this cycle.
REQ-009 Port trig_adr, in, MXADRB: trigger lookup address.
REQ-010 Port trig_pid, in, MXPIDB: trigger lookup pattern ID.
REQ-011 Port scan_start, in, 1: one-cycle pulse requesting a full-ROM scan.
REQ-012 Port scan_pid, in, MXPIDB: pattern ROM to scan, sampled with scan_start.
REQ-013 Port rom_rd, in, MXDATB: data from the selected ROM, one cycle after its address.
REQ-014 Port rom_adr, out, MXADRB: shared ROM address.
REQ-015 Port rom_pid, out, MXPIDB: shared ROM pattern select.
REQ-016 Port trig_gnt, out, 1: the trigger path owns the port this cycle.
REQ-017 Port scan_busy, out, 1: a scan is in progress.
REQ-018 Port scan_done, out, 1: one-cycle pulse when a scan completes.
REQ-019 Port scan_err, out, 1: one-cycle pulse when scan_start carries an invalid pid.
REQ-020 Port scan_crc, out, 16: checksum from the last completed scan.
REQ-021 Port scan_stall, out, 16: saturating count of scan cycles lost to trigger use in the last scan.

Function
REQ-022 The trigger path has strict priority:
- trig_gnt = trig_req, combinationally.
- When trig_req is 1: rom_adr = trig_adr and rom_pid = trig_pid.
- Otherwise rom_adr and rom_pid carry the scan address and scan pid.
REQ-023 The FSM has states IDLE, SCAN, DRAIN and DONE.
REQ-024 IDLE accepts scan_start with PID_MIN ≤ scan_pid ≤ PID_MAX: pid is latched, scan address and crc are cleared, state goes to SCAN.
REQ-025 IDLE rejects scan_start with an out-of-range pid: scan_err pulses on the next cycle and the state stays IDLE.
REQ-026 In SCAN, each cycle with trig_req = 0 issues the current scan address and increments it.
REQ-027 In SCAN, each cycle with trig_req = 1 issues nothing and increments scan_stall, saturating at 0xFFFF.
REQ-028 Issuing address 2^MXADRB−1 moves SCAN to DRAIN; the address counter does not wrap into a second pass.
REQ-029 A one-cycle-delayed issue flag marks rom_rd as scan data; each marked cycle folds crc = rotl1(crc) ^ rom_rd[15:0] ^ {14'b0, rom_rd[17:16]}.
REQ-030 Trigger cycles never fold into the checksum.
REQ-031 DRAIN lasts exactly one cycle, folds the last datum, then goes to DONE.
REQ-032 DONE drives scan_done = 1 for one cycle with scan_crc valid, then returns to IDLE.
REQ-033 scan_busy is 1 in SCAN, DRAIN and DONE.
REQ-034 scan_start is ignored while scan_busy = 1.
REQ-035 Scan latency, start pulse to scan_done, is 2^MXADRB + 2 cycles plus the stall count.
REQ-036 scan_crc and scan_stall hold their values until the next accepted scan_start, which clears both.

Reset
REQ-037 reset sampled high forces IDLE on the next edge, at any state including mid-scan.
REQ-038 On reset, these clear to 0: scan address, scan pid, crc, scan_stall, the issue flag, scan_busy, scan_done, scan_err.
REQ-039 An aborted scan produces no scan_done.
REQ-040 trig_gnt and the trigger mux are unaffected by reset (combinational).

Structure
REQ-041 MXADRB, MXDATB, MXPIDB and the pattern-ID range come from the shared pattern_params include; no local redefinition.
REQ-042 The FSM state encoding is a local parameter set.
REQ-043 The checksum fold is one sub-module, lut_crc16_fold: combinational, (crc_in, data) -> crc_out.
REQ-044 The block instantiates no ROMs; it drives the existing shared ROM address and pid path.

Verification
REQ-045 Scan pid = 0xA, trig_req held 0, ROM preloaded with data = address → scan_done exactly 4098 cycles after scan_start, scan_stall = 0, scan_crc equal to the model value.
REQ-046 Same scan with trig_req = 1 on every third cycle → scan_crc identical to REQ-045, scan_stall equal to the number of asserted cycles, rom_adr = trig_adr on every asserted cycle.
REQ-047 scan_start with scan_pid = 1, then with scan_pid = 0xB → scan_err pulses once for each, scan_busy stays 0.
REQ-048 reset asserted at scan address 0x7FF → next cycle state IDLE, scan_busy = 0, scan_crc = 0; no scan_done for the aborted scan.
REQ-049 Second scan_start at address 0x100 mid-scan → ignored; the scan completes with the REQ-045 checksum.
REQ-050 trig_req held 1 for 70000 cycles during a scan → scan_stall saturates at 0xFFFF, scan_busy stays 1; the scan completes once trig_req drops.

Source files
------------

// File: rtl/pattern_lut_scrub_pkg.sv
// Shared pattern ROM geometry, pattern-ID range and scan FSM encoding
// for the pattern LUT scrubber.
package pattern_lut_scrub_pkg;

    localparam int PAT_MXADRB  = 12;
    localparam int PAT_MXDATB  = 18;
    localparam int PAT_MXPIDB  = 4;
    localparam int PAT_PID_MIN = 2;
    localparam int PAT_PID_MAX = 10;
    localparam int CRC_W       = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } scan_state_t;

    function automatic logic [CRC_W-1:0] rotl1(input logic [CRC_W-1:0] v);
        return {v[CRC_W-2:0], v[CRC_W-1]};
    endfunction

endpackage

// File: rtl/pattern_lut_scrub_crc16_fold.sv
// One checksum step: rotate left by one, then xor in the low 16 data bits
// and the two quality bits into the bottom of the word.
module lut_crc16_fold
    import pattern_lut_scrub_pkg::*;
#(
    parameter int DATB = PAT_MXDATB
)(
    input  logic [CRC_W-1:0] crc_in,
    input  logic [DATB-1:0]  data,
    output logic [CRC_W-1:0] crc_out
);

    assign crc_out = rotl1(crc_in) ^ data[15:0] ^ {14'b0, data[17:16]};

endmodule

// File: rtl/pattern_lut_scrub.sv
// Background scrubber that walks one pattern ROM end to end and checksums it,
// sharing the ROM port with the trigger path, which always wins.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for scan_start; bad pids answered with scan_err
//   ST_SCAN  | issuing addresses on cycles the trigger path leaves free
//   ST_DRAIN | last address issued; fold its returning datum
//   ST_DONE  | scan_done pulse, scan_crc valid
module pattern_lut_scrub
    import pattern_lut_scrub_pkg::*;
#(
    parameter int MXADRB  = PAT_MXADRB,
    parameter int MXDATB  = PAT_MXDATB,
    parameter int MXPIDB  = PAT_MXPIDB,
    parameter int PID_MIN = PAT_PID_MIN,
    parameter int PID_MAX = PAT_PID_MAX
)(
    input  logic              clock,
    input  logic              reset,
    input  logic              trig_req,
    input  logic [MXADRB-1:0] trig_adr,
    input  logic [MXPIDB-1:0] trig_pid,
    input  logic              scan_start,
    input  logic [MXPIDB-1:0] scan_pid,
    input  logic [MXDATB-1:0] rom_rd,
    output logic [MXADRB-1:0] rom_adr,
    output logic [MXPIDB-1:0] rom_pid,
    output logic              trig_gnt,
    output logic              scan_busy,
    output logic              scan_done,
    output logic              scan_err,
    output logic [CRC_W-1:0]  scan_crc,
    output logic [15:0]       scan_stall
);

    localparam logic [MXPIDB-1:0] PID_LO    = MXPIDB'(PID_MIN);
    localparam logic [MXPIDB-1:0] PID_HI    = MXPIDB'(PID_MAX);
    localparam logic [15:0]       STALL_MAX = 16'hFFFF;

    scan_state_t       state_q, state_d;
    logic [MXADRB-1:0] scan_adr_q;
    logic [MXPIDB-1:0] scan_pid_q;
    logic [CRC_W-1:0]  crc_q, crc_next;
    logic [15:0]       stall_q;
    logic              issue, issue_q;
    logic              accept, reject;
    logic              err_q;
    logic              adr_last;
    logic              pid_ok;

    // Trigger path owns the port whenever it asks, independent of reset.
    assign trig_gnt = trig_req;
    assign rom_adr  = trig_req ? trig_adr : scan_adr_q;
    assign rom_pid  = trig_req ? trig_pid : scan_pid_q;

    assign adr_last = (scan_adr_q == {MXADRB{1'b1}});
    assign pid_ok   = (scan_pid >= PID_LO) && (scan_pid <= PID_HI);

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        reject  = 1'b0;
        issue   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (scan_start) begin
                    if (pid_ok) begin
                        accept  = 1'b1;
                        state_d = ST_SCAN;
                    end else begin
                        reject  = 1'b1;
                    end
                end
            end
            ST_SCAN: begin
                issue = !trig_req;
                if (issue && adr_last) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    lut_crc16_fold #(
        .DATB    (MXDATB)
    ) u_fold (
        .crc_in  (crc_q),
        .data    (rom_rd),
        .crc_out (crc_next)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            scan_adr_q <= '0;
            scan_pid_q <= '0;
            crc_q      <= '0;
            stall_q    <= '0;
            issue_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            issue_q <= issue;
            err_q   <= reject;
            if (accept) begin
                scan_pid_q <= scan_pid;
                scan_adr_q <= '0;
                crc_q      <= '0;
                stall_q    <= '0;
            end else begin
                // Counter parks on the last address rather than wrapping.
                if (issue && !adr_last) begin
                    scan_adr_q <= scan_adr_q + 1'b1;
                end
                if (state_q == ST_SCAN && trig_req && stall_q != STALL_MAX) begin
                    stall_q <= stall_q + 16'd1;
                end
                // rom_rd is scan data only on the cycle after a scan issue.
                if (issue_q) begin
                    crc_q <= crc_next;
                end
            end
        end
    end

    assign scan_busy  = (state_q != ST_IDLE);
    assign scan_done  = (state_q == ST_DONE);
    assign scan_err   = err_q;
    assign scan_crc   = crc_q;
    assign scan_stall = stall_q;

endmodule
